i2c_slave: RTL
==============

// Module: i2c_slave
// PURPOSE
//   I2C target (responder) for the FPGA2048Game I2C bus. Pairs with the on-chip i2c_master or an external controller.
//   Oversamples SCL/SDA on CLK and detects START, repeated START and STOP. Matches a 7-bit address.
//   Writes: delivers received bytes to fabric logic. Reads: shifts bytes supplied by fabric logic onto SDA.
//   No clock stretching; CLK must be at least 8x the SCL rate.
// PARAMETERS
//   SLAVE_ADDR  7'h3C  7-bit address this target answers to
//   SYNC_STAGES 2      synchronizer flops on SCL/SDA inputs (>=2)
// PORTS
//   CLK          in    1  system clock
//   ASYNC_RST_L  in    1  asynchronous active-low reset
//   SCL          in    1  bus clock (target never drives SCL)
//   SDA          inout 1  bus data, open-drain: drives 0 or 1'bz, never 1
//   RX_DATA      out   8  last byte written by the controller
//   RX_VALID     out   1  1-cycle pulse when RX_DATA updates
//   TX_DATA      in    8  next byte to return on a read
//   TX_REQ       out   1  1-cycle pulse when TX_DATA has been latched; fabric may then present the next byte
//   SELECTED     out   1  high from address match to STOP or repeated START
//   RW           out   1  R/W bit of the current transfer (1 = read)
//   BUS_BUSY     out   1  high between any START and STOP
// BEHAVIOUR
//   Reset values: all outputs 0, SDA released (z), state IDLE, shift register 0, bit counter 0.
//   Input conditioning: SCL/SDA pass through SYNC_STAGES flops; edges are taken from the last two synchronized samples.
//     scl_rise / scl_fall last 1 CLK.
//   START: SDA fall while SCL=1. Aborts any state, goes to ADDR, sets BUS_BUSY, clears SELECTED, releases SDA.
//   STOP: SDA rise while SCL=1. Goes to IDLE, clears BUS_BUSY and SELECTED, releases SDA.
//   Simultaneous condition and SCL edge cannot occur. A START seen while in any state takes priority.
//   Bits are sampled on scl_rise, MSB first. SDA drive changes only on scl_fall.
//   FSM:
//     IDLE     -> ADDR on START.
//     ADDR     8 bits shifted in. On the 8th scl_fall:
//              [7:1]==SLAVE_ADDR: SDA driven 0 (ACK), RW<=bit0, SELECTED<=1 -> ADDR_ACK.
//              Otherwise: SDA stays z -> IDLE; BUS_BUSY stays 1 until STOP.
//     ADDR_ACK on next scl_fall: RW=0 -> release SDA -> WR_DATA.
//              RW=1 -> latch TX_DATA into shifter, pulse TX_REQ, drive bit7 -> RD_DATA.
//     WR_DATA  8 bits in. On 8th scl_fall: RX_DATA<=shifter, RX_VALID pulse, drive ACK -> WR_ACK.
//     WR_ACK   on scl_fall: release SDA -> WR_DATA.
//     RD_DATA  on each scl_fall drive the next bit (0 -> drive low, 1 -> z).
//              After the 8th bit's scl_fall release SDA -> RD_ACK.
//     RD_ACK   sample SDA on scl_rise.
//              ACK (0): on scl_fall latch TX_DATA, pulse TX_REQ, drive bit7 -> RD_DATA.
//              NACK (1): release SDA -> IDLE (await STOP/START).
//   Bit counter: 3 bits, wraps 7->0 at each byte boundary. Reset to 0 on every START.
//   RX_DATA holds its value until the next written byte.
//   Repeated START mid-byte discards the partial byte, with no RX_VALID.
//   General call (addr 0) is not acknowledged.
//   Reset mid-transfer releases SDA immediately (asynchronous). The controller sees NACK/idle.
// TESTING
//   1. Write 0x78 (addr 0x3C,W), data 0xA5, STOP -> ACK on both bytes; RX_DATA=0xA5; one RX_VALID pulse; SELECTED falls at STOP.
//   2. Address 0x3D,W -> SDA never driven; SELECTED=0; RX_VALID never pulses; BUS_BUSY=1 until STOP.
//   3. Read 0x79, TX_DATA=0x5A then 0xC3, controller ACKs byte 1 and NACKs byte 2
//      -> bus carries 0x5A,0xC3; two TX_REQ pulses; SDA released after NACK.
//   4. Write 0x11, then repeated START with 0x79 read -> RX_DATA=0x11; RW switches 0->1; first read byte = TX_DATA.
//   5. Repeated START after 4 data bits of a write -> no RX_VALID; new address phase decoded correctly.
//   6. Assert ASYNC_RST_L=0 while driving an ACK -> SDA z in the same cycle; all outputs 0; next START is decoded normally.

Source files
------------

// File: rtl/i2c_slave.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// byte delivery to fabric on writes and byte fetch from fabric on reads.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h3C,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       ASYNC_RST_L,
    input  logic       SCL,
    inout  wire        SDA,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    input  logic [7:0] TX_DATA,
    output logic       TX_REQ,
    output logic       SELECTED,
    output logic       RW,
    output logic       BUS_BUSY,
    output logic [2:0] DBG_STATE
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ADDR     = 3'd1;
    localparam logic [2:0] ADDR_ACK = 3'd2;
    localparam logic [2:0] WR_DATA  = 3'd3;
    localparam logic [2:0] WR_ACK   = 3'd4;
    localparam logic [2:0] RD_DATA  = 3'd5;
    localparam logic [2:0] RD_ACK   = 3'd6;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_det;
    logic                   stop_det;

    logic [2:0] state;
    logic [7:0] shifter;
    logic [2:0] bit_cnt;
    logic       bit_seen;
    logic       nack_seen;
    logic       sda_low;
    logic       byte_done;
    logic       addr_match;

    // Open-drain: the target only ever pulls low or lets go.
    assign SDA       = sda_low ? 1'b0 : 1'bz;
    assign DBG_STATE = state;

    // Sync flops idle high so that leaving reset on an idle bus shows no edge.
    always_ff @(posedge CLK or negedge ASYNC_RST_L) begin
        if (!ASYNC_RST_L) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

    // bit_seen separates the SCL fall that ends a byte (counter wrapped to 0)
    // from the first fall of a phase, when the counter is also 0.
    assign byte_done  = bit_seen && (bit_cnt == 3'd0);
    assign addr_match = (shifter[7:1] == SLAVE_ADDR) && (shifter[7:1] != 7'd0);

    // RX_VALID and TX_REQ are single-cycle strobes with no back-pressure:
    // RX_DATA is valid while RX_VALID is high and held afterwards; on TX_REQ
    // TX_DATA has just been captured and fabric may present the next byte.
    always_ff @(posedge CLK or negedge ASYNC_RST_L) begin
        if (!ASYNC_RST_L) begin
            state     <= IDLE;
            shifter   <= 8'h00;
            bit_cnt   <= 3'd0;
            bit_seen  <= 1'b0;
            nack_seen <= 1'b0;
            sda_low   <= 1'b0;
            RX_DATA   <= 8'h00;
            RX_VALID  <= 1'b0;
            TX_REQ    <= 1'b0;
            SELECTED  <= 1'b0;
            RW        <= 1'b0;
            BUS_BUSY  <= 1'b0;
        end else begin
            RX_VALID <= 1'b0;
            TX_REQ   <= 1'b0;
            if (start_det) begin
                state    <= ADDR;
                BUS_BUSY <= 1'b1;
                SELECTED <= 1'b0;
                sda_low  <= 1'b0;
                bit_cnt  <= 3'd0;
                bit_seen <= 1'b0;
            end else if (stop_det) begin
                state    <= IDLE;
                BUS_BUSY <= 1'b0;
                SELECTED <= 1'b0;
                sda_low  <= 1'b0;
                bit_cnt  <= 3'd0;
                bit_seen <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        sda_low <= 1'b0;
                    end
                    ADDR, WR_DATA: begin
                        if (scl_rise) begin
                            shifter  <= {shifter[6:0], sda_s};
                            bit_cnt  <= bit_cnt + 3'd1;
                            bit_seen <= 1'b1;
                        end else if (scl_fall && byte_done) begin
                            bit_seen <= 1'b0;
                            if (state == WR_DATA) begin
                                RX_DATA  <= shifter;
                                RX_VALID <= 1'b1;
                                sda_low  <= 1'b1;
                                state    <= WR_ACK;
                            end else if (addr_match) begin
                                sda_low  <= 1'b1;
                                RW       <= shifter[0];
                                SELECTED <= 1'b1;
                                state    <= ADDR_ACK;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (RW) begin
                                shifter <= TX_DATA;
                                TX_REQ  <= 1'b1;
                                sda_low <= ~TX_DATA[7];
                                state   <= RD_DATA;
                            end else begin
                                sda_low <= 1'b0;
                                state   <= WR_DATA;
                            end
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            sda_low <= 1'b0;
                            state   <= WR_DATA;
                        end
                    end
                    RD_DATA: begin
                        if (scl_rise) begin
                            bit_cnt  <= bit_cnt + 3'd1;
                            bit_seen <= 1'b1;
                        end else if (scl_fall) begin
                            if (byte_done) begin
                                bit_seen <= 1'b0;
                                sda_low  <= 1'b0;
                                state    <= RD_ACK;
                            end else begin
                                shifter <= {shifter[6:0], 1'b0};
                                sda_low <= ~shifter[6];
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            nack_seen <= sda_s;
                        end else if (scl_fall) begin
                            if (!nack_seen) begin
                                shifter <= TX_DATA;
                                TX_REQ  <= 1'b1;
                                sda_low <= ~TX_DATA[7];
                                state   <= RD_DATA;
                            end else begin
                                sda_low <= 1'b0;
                                state   <= IDLE;
                            end
                        end
                    end
                    default: begin
                        sda_low <= 1'b0;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
